// File: rtl/conv_pkg.sv
// Shared types and default widths for the convolution result reader.
package conv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } conv_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that buffers result words between the memory read port and the output stream.
module skid_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (count_reg != 2'd0);
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign do_push = push && ((count_reg != 2'd2) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    data_reg <= '0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 2'd1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 2'd1;
            end
        end
    end

    assign dout  = (count_reg == 2'd0) ? '0 :
                   (rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg);
    assign full  = (count_reg == 2'd2);
    assign empty = (count_reg == 2'd0);
    assign count = count_reg;

endmodule

// File: rtl/conv_z_reader.sv
// Streams sizeX+sizeY-1 convolution results out of the result memory with
// valid/ready flow control, keeping reads in flight bounded by a 2-entry buffer.
module conv_z_reader
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   sizeX,
    input  logic [ADDR_WIDTH-1:0]   sizeY,
    output logic [ADDR_WIDTH:0]     memZ_addr,
    output logic                    memZ_rd,
    input  logic [2*DATA_WIDTH-1:0] memZ_data,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy_out,
    output logic                    done_out
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam int RW = 2 * DATA_WIDTH;
    localparam logic [LW-1:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    conv_state_t   state_reg;
    logic [LW-1:0] len_reg;
    logic [LW-1:0] len_next;
    logic [LW-1:0] rd_cnt_reg;
    logic [LW-1:0] beat_cnt_reg;
    logic          pend_reg;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    fifo_count;
    logic          pop;
    logic [2:0]    slots_used;

    assign len_next = ((sizeX == '0) || (sizeY == '0)) ? '0 :
                      ({1'b0, sizeX} + {1'b0, sizeY} - LEN_ONE);

    assign pop = !fifo_empty && out_ready;

    // Count the slot being popped this cycle as free, so reads keep one beat per cycle.
    assign slots_used = {1'b0, fifo_count} + {2'b00, pend_reg} - {2'b00, pop};

    assign memZ_rd   = (state_reg == ST_STREAM) && (rd_cnt_reg < len_reg) &&
                       (slots_used < 3'd2) && !(fifo_full && !pop);
    assign memZ_addr = rd_cnt_reg;

    assign out_valid = !fifo_empty;
    assign out_last  = out_valid && (beat_cnt_reg == (len_reg - LEN_ONE));
    assign busy_out  = (state_reg == ST_STREAM);
    assign done_out  = (state_reg == ST_DONE);

    skid_fifo2 #(
        .WIDTH (RW)
    ) u_buf (
        .clk   (clk),
        .rstn  (rstn),
        .push  (pend_reg),
        .din   (memZ_data),
        .pop   (pop),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            len_reg      <= '0;
            rd_cnt_reg   <= '0;
            beat_cnt_reg <= '0;
            pend_reg     <= 1'b0;
        end else begin
            // Read data returns one cycle after the strobe; capture it then.
            pend_reg <= memZ_rd;
            if (memZ_rd) begin
                rd_cnt_reg <= rd_cnt_reg + LEN_ONE;
            end
            if (pop) begin
                beat_cnt_reg <= beat_cnt_reg + LEN_ONE;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        len_reg      <= len_next;
                        rd_cnt_reg   <= '0;
                        beat_cnt_reg <= '0;
                        state_reg    <= (len_next == '0) ? ST_DONE : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (pop && out_last) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rd_cnt_reg   <= '0;
                    beat_cnt_reg <= '0;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/conv_z_reader.md
CONV_Z_READER -- requirements
Module: conv_z_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of conv operand samples; result width is 2*DATA_WIDTH.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: width of sizeX and sizeY; the result address is ADDR_WIDTH+1 bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to stream results; honoured only in IDLE.
REQ-006 SHALL have ports sizeX and sizeY, input, ADDR_WIDTH bits each: operand lengths, sampled on an accepted start.
REQ-007 SHALL have port memZ_addr, output, ADDR_WIDTH+1 bits: result-memory read address.
REQ-008 SHALL have port memZ_rd, output, 1 bit: read strobe.
- memZ_data is valid exactly one cycle after memZ_rd=1.
REQ-009 SHALL have port memZ_data, input, 2*DATA_WIDTH bits: read data from the result memory.
REQ-010 SHALL have port out_data, output, 2*DATA_WIDTH bits: streamed result.
REQ-011 SHALL have port out_valid, output, 1 bit.
REQ-012 SHALL have port out_ready, input, 1 bit: a beat transfers when out_valid and out_ready are both 1.
REQ-013 SHALL have port out_last, output, 1 bit: marks the final beat, qualified by out_valid.
REQ-014 SHALL have port busy_out, output, 1 bit.
REQ-015 SHALL have port done_out, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 SHALL compute stream length N = sizeX+sizeY-1 at ADDR_WIDTH+1 bits when start is accepted.
- If sizeX==0 or sizeY==0, N SHALL be 0.
REQ-017 SHALL implement FSM states IDLE, STREAM, DONE.
- IDLE->STREAM on start with N>0.
- IDLE->DONE on start with N==0.
- STREAM->DONE when beat N is accepted.
- DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL assert done_out only in DONE and busy_out only in STREAM; start SHALL be ignored in STREAM and DONE.
REQ-019 SHALL issue reads at addresses 0,1,...,N-1 in order, each exactly once, with memZ_addr held at the issued value while memZ_rd=1.
REQ-020 SHALL capture memZ_data into a 2-entry output buffer on the cycle after each read.
REQ-021 SHALL assert memZ_rd only while (buffer occupancy + reads in flight) < 2 and reads issued < N, so that the buffer never overflows.
REQ-022 SHALL present beats from the buffer head in order.
- out_valid=1 iff the buffer is non-empty.
- out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, with out_ready held 1, sustain one beat per cycle after the first beat.
REQ-024 SHALL timing the first beat as follows.
- memZ_rd=1 with addr 0 in the first STREAM cycle.
- out_valid=1 two cycles later.
REQ-025 SHALL assert out_last only on beat index N-1.
REQ-026 SHALL allow a simultaneous pop and capture in the same cycle, leaving occupancy unchanged.
REQ-027 SHALL enter DONE on the edge at which the last beat is accepted; done_out is high the following cycle.

Reset
REQ-028 SHALL, when rstn=0 at a clock edge, force all of the following, including mid-STREAM:
- state to IDLE;
- read counter, beat counter and buffer to empty;
- memZ_rd, out_valid, out_last, busy_out and done_out to 0;
- memZ_addr and out_data to 0.
REQ-029 SHALL discard any in-flight read data returned after reset.

Structure
REQ-030 SHALL place the FSM state enum and the default DATA_WIDTH and ADDR_WIDTH constants in shared package conv_pkg.
REQ-031 SHALL implement the 2-entry buffer as sub-module skid_fifo2, parameterised by width, with push, pop, full, empty and count.

Verification
REQ-032 SHALL cover nominal streaming: memZ={10,20,30,40}, sizeX=3, sizeY=2, out_ready=1 -> 4 consecutive beats 10,20,30,40, out_last on 40, done_out one cycle later.
REQ-033 SHALL cover backpressure: same data, out_ready toggling 1,0,0,1,... -> no loss or duplication, and data held stable while stalled.
REQ-034 SHALL cover empty size: sizeX=0, sizeY=5, start -> no memZ_rd, no out_valid, done_out pulse the cycle after start.
REQ-035 SHALL cover start while busy: start pulsed mid-STREAM -> ignored, and N is unchanged from the first start.
REQ-036 SHALL cover reset mid-stream: rstn=0 after 2 beats -> all outputs 0 next cycle; a new start restreams from address 0.
REQ-037 SHALL cover maximum size: sizeX=31, sizeY=31 -> 61 beats at addresses 0..60 with no address wrap.
